// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl -- run / step / halt sequencer for the MIPS core.
//
// The CPU always runs on the board clock. This block only produces a
// registered, single-cycle clock-enable pulse (cpu_en) that the CPU
// qualifies all of its state updates with.
//
// Modes:
//   IDLE (00) : waiting; mode_run starts RUN, a step_req rising edge starts STEP
//   RUN  (01) : one pulse every rate+1 clks, halted by halt_req or breakpoint
//   STEP (10) : exactly one pulse per step press (breakpoint ignored)
//   HALT (11) : no pulses; leaves once mode_run and halt_req are both low
//
// Ports:
//   clk, rst_n   board clock, asynchronous active-low reset
//   mode_run     level, free-run request
//   step_req     debounced level; rising edge requests a step
//   halt_req     level, forces HALT from RUN
//   rate[N-1:0]  clks between pulses minus one (0 = pulse every clk)
//   bp_en        breakpoint enable
//   bp_addr, pc  breakpoint address and current CPU PC
//   cnt_clr      synchronous clear of cycle_cnt
//   cpu_en       registered one-cycle CPU enable
//   state[1:0]   current mode (encoding above)
//   halted       registered, high while in HALT
//   cycle_cnt    number of cpu_en pulses issued (wraps)
//
// Optional build macro CPU_CLK_CTRL_BURST_EN:
//   adds burst_len[7:0]; STEP then issues burst_len+1 pulses spaced by rate,
//   aborted into HALT by halt_req or a breakpoint match (the first pulse of
//   the burst ignores the breakpoint).
// ---------------------------------------------------------------------------
module cpu_clk_ctrl #(
  parameter int N  = 28,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_run,
  input  logic          step_req,
  input  logic          halt_req,
  input  logic [N-1:0]  rate,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  input  logic          cnt_clr,
`ifdef CPU_CLK_CTRL_BURST_EN
  input  logic [7:0]    burst_len,
`endif
  output logic          cpu_en,
  output logic [1:0]    state,
  output logic          halted,
  output logic [31:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t         cur_state, nxt_state;
  logic [N-1:0]   div_cnt, div_nxt;
  logic           step_q;
  logic           step_rise;
  logic           tick;
  logic           bp_hit;
  logic           en_d;

`ifdef CPU_CLK_CTRL_BURST_EN
  logic [8:0]     burst_rem, burst_rem_nxt;  // pulses still owed in this burst
  logic           step_first;                // first cycle spent in STEP
`endif

  assign step_rise = step_req & ~step_q;
  // >= rather than == so that lowering rate mid-count ticks immediately
  // instead of wrapping the counter through 2^N.
  assign tick      = (div_cnt >= rate);
  assign bp_hit    = bp_en && (pc == bp_addr);
  assign state     = cur_state;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns nxt_state; no latch inferred.
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (mode_run)       nxt_state = RUN;
        else if (step_rise) nxt_state = STEP;
      end
      RUN: begin
        if (halt_req)             nxt_state = HALT;
        else if (tick && bp_hit)  nxt_state = HALT;
        else if (!mode_run)       nxt_state = IDLE;
      end
      STEP: begin
`ifdef CPU_CLK_CTRL_BURST_EN
        if (step_first) begin
          if (burst_rem == 9'd1) nxt_state = IDLE;
        end else if (halt_req) begin
          nxt_state = HALT;
        end else if (tick && bp_hit) begin
          nxt_state = HALT;
        end else if (tick && (burst_rem == 9'd1)) begin
          nxt_state = IDLE;
        end
`else
        nxt_state = IDLE;
`endif
      end
      HALT: begin
        if (!mode_run && !halt_req) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath decode: next pulse, next divider count
  // -------------------------------------------------------------------------
  always_comb begin
    en_d    = 1'b0;
    div_nxt = '0;   // divider is held at 0 outside its active states
`ifdef CPU_CLK_CTRL_BURST_EN
    burst_rem_nxt = burst_rem;
`endif
    case (cur_state)
      IDLE: begin
`ifdef CPU_CLK_CTRL_BURST_EN
        burst_rem_nxt = {1'b0, burst_len} + 9'd1;
`endif
      end
      RUN: begin
        div_nxt = tick ? '0 : div_cnt + N'(1);
        // tick already implies the breakpoint compare is live here
        en_d    = tick && !halt_req && !bp_hit && mode_run;
      end
      STEP: begin
`ifdef CPU_CLK_CTRL_BURST_EN
        if (step_first) begin
          // first pulse is unconditional so a breakpoint can be stepped past
          en_d          = 1'b1;
          burst_rem_nxt = burst_rem - 9'd1;
        end else begin
          div_nxt = tick ? '0 : div_cnt + N'(1);
          if (tick && !halt_req && !bp_hit) begin
            en_d          = 1'b1;
            burst_rem_nxt = burst_rem - 9'd1;
          end
        end
`else
        en_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en    <= 1'b0;
      halted    <= 1'b0;
      div_cnt   <= '0;
      step_q    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_en  <= en_d;
      halted  <= (nxt_state == HALT);
      div_cnt <= div_nxt;
      step_q  <= step_req;
      // clear wins over a simultaneous increment
      if (cnt_clr)     cycle_cnt <= '0;
      else if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

`ifdef CPU_CLK_CTRL_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_rem  <= '0;
      step_first <= 1'b0;
    end else begin
      burst_rem  <= burst_rem_nxt;
      step_first <= (cur_state != STEP);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clk_ctrl -- directed self-checking bench for cpu_clk_ctrl.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each clk_cycle() call observes the result of exactly one edge.
// ---------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

  localparam int N  = 28;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          mode_run;
  logic          step_req;
  logic          halt_req;
  logic [N-1:0]  rate;
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic [AW-1:0] pc;
  logic          cnt_clr;
`ifdef CPU_CLK_CTRL_BURST_EN
  logic [7:0]    burst_len;
`endif
  logic          cpu_en;
  logic [1:0]    state;
  logic          halted;
  logic [31:0]   cycle_cnt;

  int checks = 0;
  int errors = 0;

  cpu_clk_ctrl #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_run  (mode_run),
    .step_req  (step_req),
    .halt_req  (halt_req),
    .rate      (rate),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cnt_clr   (cnt_clr),
`ifdef CPU_CLK_CTRL_BURST_EN
    .burst_len (burst_len),
`endif
    .cpu_en    (cpu_en),
    .state     (state),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    mode_run = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    rate     = '0;
    bp_en    = 1'b0;
    bp_addr  = '0;
    pc       = '0;
    cnt_clr  = 1'b0;
`ifdef CPU_CLK_CTRL_BURST_EN
    burst_len = '0;
`endif
    clk_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'b00)      begin errors++; $display("FAIL reset_state: got %0h expected 0", state); end
    checks++; if (cpu_en !== 1'b0)      begin errors++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (cycle_cnt !== 32'd0)  begin errors++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
    clk_cycle();
    checks++; if (state !== 2'b00)      begin errors++; $display("FAIL reset_idle_hold: got %0h expected 0", state); end
  endtask

  // rate=3: first pulse 4 clks after RUN entry, then every 4 clks.
  task automatic test_run_rate3();
    logic exp_en;
    do_reset();
    rate     = 28'd3;
    mode_run = 1'b1;
    clk_cycle();   // entry edge
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_entry_state: got %0h expected 1", state); end
    for (int k = 1; k <= 20; k++) begin
      clk_cycle();
      exp_en = ((k % 4) == 0);
      checks++; if (cpu_en !== exp_en) begin errors++; $display("FAIL run_rate3_pulse clk %0d: got %0b expected %0b", k, cpu_en, exp_en); end
    end
    clk_cycle();   // last pulse gets counted here
    checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL run_rate3_count: got %0d expected 5", cycle_cnt); end
    checks++; if (state !== 2'b01)     begin errors++; $display("FAIL run_rate3_state: got %0h expected 1", state); end
  endtask

  // rate 9 -> 2 while divider is 7: pulse on the next edge, then every 3.
  task automatic test_rate_change();
    logic exp_en;
    do_reset();
    rate     = 28'd9;
    mode_run = 1'b1;
    clk_cycle();   // entry; divider = 0
    for (int k = 1; k <= 14; k++) begin
      clk_cycle();
      if (k == 7) rate = 28'd2;   // divider now holds 7
      exp_en = (k == 8) || (k == 11) || (k == 14);
      checks++; if (cpu_en !== exp_en) begin errors++; $display("FAIL rate_change_pulse clk %0d: got %0b expected %0b", k, cpu_en, exp_en); end
    end
  endtask

  // step_req held 10 clks -> one pulse, STEP for one cycle.
  task automatic test_step();
    logic [1:0] exp_st;
    logic       exp_en;
    do_reset();
    rate     = 28'd5;
    step_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      clk_cycle();
      exp_st = (k == 1) ? 2'b10 : 2'b00;
      exp_en = (k == 2);
      checks++; if (state !== exp_st)  begin errors++; $display("FAIL step_state clk %0d: got %0h expected %0h", k, state, exp_st); end
      checks++; if (cpu_en !== exp_en) begin errors++; $display("FAIL step_pulse clk %0d: got %0b expected %0b", k, cpu_en, exp_en); end
    end
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", cycle_cnt); end
    step_req = 1'b0;
  endtask

  // pc models the address of the next instruction: it advances as soon as a
  // pulse is seen, so the controller compares against the upcoming PC.
  task automatic test_breakpoint();
    logic exp_en;
    do_reset();
    rate     = 28'd0;
    bp_en    = 1'b1;
    bp_addr  = 32'h40;
    pc       = 32'h30;
    mode_run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      clk_cycle();
      exp_en = (k >= 2) && (k <= 5);   // pulses for 0x30,0x34,0x38,0x3C
      checks++; if (cpu_en !== exp_en) begin errors++; $display("FAIL bp_pulse clk %0d: got %0b expected %0b", k, cpu_en, exp_en); end
      if (cpu_en) pc = pc + 32'd4;
    end
    checks++; if (state !== 2'b11)     begin errors++; $display("FAIL bp_state: got %0h expected 3", state); end
    checks++; if (halted !== 1'b1)     begin errors++; $display("FAIL bp_halted: got %0b expected 1", halted); end
    checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cycle_cnt); end
    // step press in HALT is ignored
    step_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      clk_cycle();
      checks++; if (state !== 2'b11 || cpu_en !== 1'b0) begin errors++; $display("FAIL bp_step_ignored clk %0d: got state %0h en %0b expected state 3 en 0", k, state, cpu_en); end
    end
    step_req = 1'b0;
    clk_cycle();
    mode_run = 1'b0;
    clk_cycle();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL bp_release_state: got %0h expected 0", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bp_release_halted: got %0b expected 0", halted); end
    // step past the breakpoint (pc still equals bp_addr)
    step_req = 1'b1;
    clk_cycle();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL bp_step_state: got %0h expected 2", state); end
    clk_cycle();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL bp_step_pulse: got %0b expected 1", cpu_en); end
    clk_cycle();
    checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL bp_step_count: got %0d expected 5", cycle_cnt); end
    step_req = 1'b0;
  endtask

  task automatic test_priority();
    // halt_req beats mode_run=0
    do_reset();
    rate     = 28'd0;
    mode_run = 1'b1;
    clk_cycle();
    clk_cycle();
    halt_req = 1'b1;
    mode_run = 1'b0;
    clk_cycle();
    checks++; if (state !== 2'b11)  begin errors++; $display("FAIL prio_halt_state: got %0h expected 3", state); end
    checks++; if (cpu_en !== 1'b0)  begin errors++; $display("FAIL prio_halt_pulse: got %0b expected 0", cpu_en); end
    checks++; if (halted !== 1'b1)  begin errors++; $display("FAIL prio_halt_halted: got %0b expected 1", halted); end
    clk_cycle();
    checks++; if (state !== 2'b11)  begin errors++; $display("FAIL prio_halt_hold: got %0h expected 3", state); end
    halt_req = 1'b0;
    clk_cycle();
    checks++; if (state !== 2'b00)  begin errors++; $display("FAIL prio_halt_exit: got %0h expected 0", state); end
    // breakpoint beats mode_run=0
    do_reset();
    rate     = 28'd0;
    bp_en    = 1'b1;
    bp_addr  = 32'h100;
    pc       = 32'h100;
    mode_run = 1'b1;
    clk_cycle();
    mode_run = 1'b0;
    clk_cycle();
    checks++; if (state !== 2'b11)  begin errors++; $display("FAIL prio_bp_state: got %0h expected 3", state); end
    checks++; if (cpu_en !== 1'b0)  begin errors++; $display("FAIL prio_bp_pulse: got %0b expected 0", cpu_en); end
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    rate     = 28'd0;
    mode_run = 1'b1;
    clk_cycle();
    clk_cycle();
    clk_cycle();
    checks++; if (cpu_en !== 1'b1 || cycle_cnt !== 32'd1) begin errors++; $display("FAIL clr_setup: got en %0b cnt %0d expected en 1 cnt 1", cpu_en, cycle_cnt); end
    cnt_clr = 1'b1;
    clk_cycle();
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", cycle_cnt); end
    cnt_clr = 1'b0;
    clk_cycle();
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL clr_resume: got %0d expected 1", cycle_cnt); end
    // asynchronous reset in the middle of a clock period
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'b00)     begin errors++; $display("FAIL async_rst_state: got %0h expected 0", state); end
    checks++; if (cpu_en !== 1'b0)     begin errors++; $display("FAIL async_rst_cpu_en: got %0b expected 0", cpu_en); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL async_rst_halted: got %0b expected 0", halted); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", cycle_cnt); end
    clk_cycle();
    rst_n = 1'b1;
  endtask

`ifdef CPU_CLK_CTRL_BURST_EN
  // burst_len=3, rate=1: four pulses two clks apart, then IDLE.
  task automatic test_burst();
    logic exp_en;
    do_reset();
    rate      = 28'd1;
    burst_len = 8'd3;
    step_req  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      clk_cycle();
      exp_en = (k == 2) || (k == 4) || (k == 6) || (k == 8);
      checks++; if (cpu_en !== exp_en) begin errors++; $display("FAIL burst_pulse clk %0d: got %0b expected %0b", k, cpu_en, exp_en); end
    end
    checks++; if (state !== 2'b00)     begin errors++; $display("FAIL burst_state: got %0h expected 0", state); end
    checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL burst_count: got %0d expected 4", cycle_cnt); end
    step_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_run_rate3();
    test_rate_change();
    test_step();
    test_breakpoint();
    test_priority();
    test_clear_and_reset();
`ifdef CPU_CLK_CTRL_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Run/step/halt controller that sequences the MIPS CPU core.
- Produces a single-cycle clock-enable pulse (cpu_en) at a programmable rate from the board clock. The CPU is never driven by a derived clock.
- Supports free-run, single-step and PC breakpoint halt.
- Sits between the board I/O (switches, debounced buttons) and the CPU datapath. Exports state and a retired-cycle count for the display logic.

Parameters:
- N, 28, bit-width of the rate divider counter and of the rate port.
- AW, 32, width of pc and bp_addr.

Ports:
- clk  in  1  board clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_run  in  1  level; 1 = free-run requested.
- step_req  in  1  level, already debounced; a rising edge requests one step.
- halt_req  in  1  level; forces HALT from RUN.
- rate  in  N  cycles between pulses minus one; 0 = pulse every clk.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  AW  breakpoint PC.
- pc  in  AW  current CPU PC.
- cnt_clr  in  1  synchronous clear of cycle_cnt.
- cpu_en  out  1  registered one-cycle CPU enable pulse.
- state  out  2  IDLE=00, RUN=01, STEP=10, HALT=11.
- halted  out  1  registered; 1 while in HALT.
- cycle_cnt  out  32  count of cpu_en pulses issued.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; cpu_en=0; halted=0; cycle_cnt=0; divider count=0; step edge register=0.
- Step edge detect: step_q <= step_req each cycle; step_rise = step_req & ~step_q.
- Divider:
  - Active only in RUN. Cleared to 0 on every transition into RUN.
  - tick = (cnt >= rate). On tick, cnt <= 0; otherwise cnt <= cnt + 1.
  - The >= compare means that lowering rate mid-count ticks on the next cycle (no 2^N wrap).
- Pulse timing: cpu_en is registered and asserted the cycle after its cause.
  - With rate=R in steady RUN, pulses occur exactly every R+1 clks.
  - The first pulse comes R+1 clks after RUN entry.
- IDLE:
  - mode_run=1 -> RUN.
  - Otherwise, step_rise -> STEP.
  - mode_run takes priority over step.
- RUN:
  - halt_req=1 -> HALT; no pulse that cycle.
  - Else if tick & bp_en & (pc == bp_addr) -> HALT; the pulse is suppressed.
  - Else if mode_run=0 -> IDLE; no pulse.
  - Else cpu_en <= tick.
  - Priority: halt_req > breakpoint > mode_run=0.
- STEP:
  - Entry cycle: cpu_en <= 1. Next cycle: return to IDLE.
  - Exactly one pulse per step_rise, independent of rate.
  - The breakpoint is ignored in STEP, so stepping past a breakpoint is allowed.
  - step_req held high does not repeat.
- HALT:
  - cpu_en=0; halted=1.
  - mode_run=0 and halt_req=0 -> IDLE.
  - step_rise is ignored.
- cycle_cnt:
  - Increments by 1 on each cycle where cpu_en=1; wraps 0xFFFFFFFF -> 0.
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.
- Mid-operation reset: returns immediately to the reset values. An in-flight pulse is dropped.

Optional Feature:
- Macro: CPU_CLK_CTRL_BURST_EN.
- Defined:
  - Adds input burst_len[7:0].
  - STEP issues burst_len+1 pulses, spaced by rate using the divider.
  - halt_req or a breakpoint match aborts the burst into HALT; the breakpoint is still ignored on the first pulse.
  - Then -> IDLE.
- Undefined: no port; STEP issues exactly one pulse as above.

Test Plan:
- Run at rate=3, mode_run=1 for 20 clks:
  - cpu_en pulses every 4 clks, first pulse at clk 4 after entry.
  - cycle_cnt=5 at the end.
  - state=01.
- Rate change in RUN: rate 9 -> 2 while cnt=7 -> pulse on the next cycle, then every 3 clks.
- Step from IDLE: step_req held high for 10 clks -> exactly one cpu_en pulse; state 00->10->00; cycle_cnt +1.
- Breakpoint in RUN:
  - Setup: rate=0, bp_en=1, bp_addr=0x40, pc advancing by 4 from 0x30 on each cpu_en.
  - Pulses occur at pc=0x30, 0x34, 0x38, 0x3C.
  - At pc=0x40 the pulse is suppressed; state=11; halted=1.
  - Then a step press is ignored; mode_run=0 -> IDLE; a step press then issues a pulse at pc=0x40.
- Priority and clear:
  - halt_req and mode_run fall together -> HALT.
  - cnt_clr together with cpu_en -> cycle_cnt=0.
  - rst_n low mid-RUN -> all outputs at reset values asynchronously.
- (Burst, when the macro is defined) burst_len=3, rate=1 -> 4 pulses 2 clks apart, then IDLE; cycle_cnt +4.
